// File: rtl/sound_arbiter.sv
// sound_arbiter
//   Shares the single speaker pin between the score, jump and game-over sound players.
//   One-cycle request pulses from game logic fire the matching player's one-cycle start
//   pulse; the chosen player's square wave is routed (registered) to wave_out. Players
//   have no done signal, so each sound is timed with a per-source cycle budget followed
//   by a forced silent gap. Priority: over > jump > score.
//
//   Optional feature: define SOUND_QUEUE_EN to keep one pending flag per source for
//   deferred lower-priority requests, served highest-first once the gap ends. Without
//   it, deferred lower-priority requests are dropped and no pending state exists.
//
// Ports
//   clk, rst_n                          clock, asynchronous active-low reset
//   score_req, jump_req, over_req       one-cycle play requests
//   mute                                level; forces wave_out low, timing unaffected
//   wave_score, wave_jump, wave_over    player square waves
//   start_score, start_jump, start_over one-cycle start pulses to the players
//   wave_out                            registered speaker output
//   active_src                          0 none, 1 score, 2 jump, 3 over (during PLAY)
//   busy                                high in START/PLAY/GAP
module sound_arbiter #(
  parameter int unsigned CNT_W        = 23,
  parameter int unsigned SCORE_CYCLES = 2_500_000,
  parameter int unsigned JUMP_CYCLES  = 5_000_000,
  parameter int unsigned OVER_CYCLES  = 6_200_031,
  parameter int unsigned GAP_CYCLES   = 50_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       score_req,
  input  logic       jump_req,
  input  logic       over_req,
  input  logic       mute,
  input  logic       wave_score,
  input  logic       wave_jump,
  input  logic       wave_over,
  output logic       start_score,
  output logic       start_jump,
  output logic       start_over,
  output logic       wave_out,
  output logic [1:0] active_src,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StStart, StPlay, StGap} state_e;

  state_e           state_q;
  logic [1:0]       src_q;    // source started/playing; kept through GAP for priority compares
  logic [CNT_W-1:0] cnt_q;

  logic [2:0] req;
  logic [2:0] pend;
  logic [1:0] req_top, all_top, go_src;
  logic       go, cur_hit, cnt_zero, sel_wave;

  // Source codes double as priority: a larger code wins.
  function automatic logic [1:0] top_src(input logic [2:0] v);
    if (v[2]) return 2'd3;
    if (v[1]) return 2'd2;
    if (v[0]) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [2:0] src_bit(input logic [1:0] s);
    case (s)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] src_len(input logic [1:0] s);
    case (s)
      2'd1:    return CNT_W'(SCORE_CYCLES - 1);
      2'd2:    return CNT_W'(JUMP_CYCLES - 1);
      default: return CNT_W'(OVER_CYCLES - 1);
    endcase
  endfunction

  assign req = {over_req, jump_req, score_req};

  always_comb begin
    req_top  = top_src(req);
    all_top  = top_src(req | pend);
    cur_hit  = |(req & src_bit(src_q));
    cnt_zero = (cnt_q == '0);
    go       = 1'b0;
    go_src   = req_top;
    unique case (state_q)
      StIdle: begin
        go     = |(req | pend);
        go_src = all_top;
      end
      StStart: go = (req_top > src_q);
      // Restart on same source; any request on the final PLAY cycle is taken.
      StPlay:  go = (req_top > src_q) || cur_hit || (cnt_zero && (|req));
      StGap: begin
        if (cnt_zero && (|(req | pend))) begin
          go     = 1'b1;
          go_src = all_top;
        end else begin
          go = (req_top > src_q) || cur_hit;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    case (src_q)
      2'd1:    sel_wave = wave_score;
      2'd2:    sel_wave = wave_jump;
      2'd3:    sel_wave = wave_over;
      default: sel_wave = 1'b0;
    endcase
  end

`ifdef SOUND_QUEUE_EN
  logic [2:0] pend_d;
  logic [1:0] win_src;

  function automatic logic [2:0] lower_mask(input logic [1:0] s);
    case (s)
      2'd2:    return 3'b001;
      2'd3:    return 3'b011;
      default: return 3'b000;
    endcase
  endfunction

  // Requests losing to this cycle's winner are remembered; a flag clears on its START.
  always_comb begin
    win_src = go ? go_src : src_q;
    pend_d  = (pend | (req & lower_mask(win_src))) & ~(go ? src_bit(go_src) : 3'b000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 3'b000;
    end else begin
      pend <= pend_d;
    end
  end
`else
  assign pend = 3'b000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      src_q       <= 2'd0;
      cnt_q       <= '0;
      start_score <= 1'b0;
      start_jump  <= 1'b0;
      start_over  <= 1'b0;
      wave_out    <= 1'b0;
      active_src  <= 2'd0;
      busy        <= 1'b0;
    end else begin
      {start_over, start_jump, start_score} <= 3'b000;
      // One-cycle lag behind the selected player wave.
      wave_out <= (state_q == StPlay) & sel_wave & ~mute;
      if (go) begin
        state_q    <= StStart;
        src_q      <= go_src;
        active_src <= 2'd0;
        busy       <= 1'b1;
        {start_over, start_jump, start_score} <= src_bit(go_src);
      end else begin
        unique case (state_q)
          StIdle: ;
          StStart: begin
            state_q    <= StPlay;
            cnt_q      <= src_len(src_q);
            active_src <= src_q;
          end
          StPlay: begin
            if (cnt_zero) begin
              state_q    <= StGap;
              cnt_q      <= CNT_W'(GAP_CYCLES - 1);
              active_src <= 2'd0;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          StGap: begin
            if (cnt_zero) begin
              state_q <= StIdle;
              busy    <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
